// File: rtl/pll_phase_stepper.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pll_phase_stepper                                             |
// | Sequences PLL dynamic phase-shift steps (phasestep/updown/select/done). |
// | Option : define PHASE_POSITION_EN to add the signed phase_position port.|
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module pll_phase_stepper #(
  parameter int SEL_WIDTH   = 3,
  parameter int COUNT_WIDTH = 8,
  parameter int TIMEOUT     = 255,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEL_WIDTH-1:0]   req_sel,
  input  logic                   req_dir,
  input  logic [COUNT_WIDTH-1:0] req_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
`ifdef PHASE_POSITION_EN
  output logic signed [15:0]     phase_position,
`endif
  input  logic                   pll_locked,
  input  logic                   pll_phasedone,
  output logic                   pll_phasestep,
  output logic                   pll_phaseupdown,
  output logic [SEL_WIDTH-1:0]   pll_phasecounterselect
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_STEP      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  state_t                 state_q;
  logic                   lock_meta_q, lock_s_q;
  logic                   pd_meta_q, pd_s_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   dir_q;
  logic [COUNT_WIDTH-1:0] rem_q;
  logic                   step_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [GAP_W-1:0]       gap_q;
  logic                   done_q, error_q;
  logic                   w_xfer;
  logic                   w_step_done;

  // Both PLL status lines are asynchronous to the scan clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pd_meta_q   <= 1'b0;
      pd_s_q      <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      pd_meta_q   <= pll_phasedone;
      pd_s_q      <= pd_meta_q;
    end
  end

  // Ready stays low during the done/error pulse so a new transfer starts after it.
  assign req_ready   = (state_q == S_IDLE) && lock_s_q && !done_q && !error_q;
  assign w_xfer      = req_valid && req_ready;
  assign w_step_done = (state_q == S_WAIT_HIGH) && pd_s_q && lock_s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      step_q  <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if ((state_q != S_IDLE) && !lock_s_q) begin
        state_q <= S_IDLE;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (w_xfer) begin
              sel_q <= req_sel;
              dir_q <= req_dir;
              rem_q <= req_count;
              if (req_count == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_SETUP;
              end
            end
          end
          S_SETUP: begin
            step_q  <= 1'b0;
            state_q <= S_STEP;
          end
          S_STEP: begin
            if (step_q) begin
              rem_q   <= rem_q - COUNT_WIDTH'(1);
              tmo_q   <= '0;
              state_q <= S_WAIT_LOW;
            end else begin
              step_q <= 1'b1;
            end
          end
          S_WAIT_LOW: begin
            if (!pd_s_q) begin
              tmo_q   <= '0;
              state_q <= S_WAIT_HIGH;
            end else if (tmo_q == C_TMO_LAST) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          S_WAIT_HIGH: begin
            if (pd_s_q) begin
              if (rem_q == '0) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                gap_q   <= '0;
                state_q <= S_GAP;
              end
            end else if (tmo_q == C_TMO_LAST) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          S_GAP: begin
            // Select and direction stay driven, so the next step skips SETUP.
            if (gap_q == C_GAP_LAST) begin
              step_q  <= 1'b0;
              state_q <= S_STEP;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PHASE_POSITION_EN
  logic signed [15:0] pos_q;

  // Only counter 0 is tracked; steps finished before an abort are kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q <= '0;
    end else if (w_step_done && (sel_q == '0)) begin
      pos_q <= dir_q ? (pos_q + 16'sd1) : (pos_q - 16'sd1);
    end
  end

  assign phase_position = pos_q;
`endif

  assign busy                   = (state_q != S_IDLE);
  assign done                   = done_q;
  assign error                  = error_q;
  assign pll_phasestep          = (state_q == S_STEP);
  assign pll_phaseupdown        = busy && dir_q;
  assign pll_phasecounterselect = busy ? sel_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_stepper.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_pll_phase_stepper                                          |
// | Directed bench with a PLL phasedone model and a request scoreboard.    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_pll_phase_stepper;
  localparam int TIMEOUT = 255;
  localparam int PD_LOW  = 4;

  typedef struct {
    bit is_err;
    int steps;
  } exp_t;

  exp_t exp_q[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_dir = 1'b0;
  logic [2:0] req_sel = 3'd0;
  logic [7:0] req_count = 8'd0;
  logic       pll_locked = 1'b0;
  logic       pll_phasedone = 1'b1;
  logic       req_ready, busy, done, error;
  logic       pll_phasestep, pll_phaseupdown;
  logic [2:0] pll_phasecounterselect;
`ifdef PHASE_POSITION_EN
  logic signed [15:0] phase_position;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   step_pulses = 0;
  int   step_cyc = 0;
  int   last_step_cyc = 0;
  int   pd_cnt = 0;
  logic prev_step = 1'b0;
  logic [2:0] cur_sel = 3'd0;
  logic cur_dir = 1'b0;
  bit   pll_stuck = 1'b0;

  pll_phase_stepper #(
    .SEL_WIDTH(3), .COUNT_WIDTH(8), .TIMEOUT(TIMEOUT), .GAP_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_count(req_count),
    .busy(busy), .done(done), .error(error),
`ifdef PHASE_POSITION_EN
    .phase_position(phase_position),
`endif
    .pll_locked(pll_locked), .pll_phasedone(pll_phasedone),
    .pll_phasestep(pll_phasestep), .pll_phaseupdown(pll_phaseupdown),
    .pll_phasecounterselect(pll_phasecounterselect)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // PLL model: phasedone drops while phasestep is seen, rises PD_LOW cycles later.
  always @(posedge clock) begin
    if (pll_phasestep && !pll_stuck) begin
      pll_phasedone <= 1'b0;
      pd_cnt        <= PD_LOW;
    end else if (pd_cnt != 0) begin
      pd_cnt <= pd_cnt - 1;
      if (pd_cnt == 1) pll_phasedone <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (pll_phasestep === 1'b1) begin
      step_cyc++;
      if (!prev_step) step_pulses++;
      last_step_cyc = cyc;
      check("step_sel_dir", 32'({pll_phasecounterselect, pll_phaseupdown}),
            32'({cur_sel, cur_dir}));
    end
    prev_step = pll_phasestep;
    if (done || error) check("done_error_excl", 32'(done && error), 32'(0));
  end

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic send(input logic [2:0] s, input logic d, input logic [7:0] c);
    step_pulses = 0;
    step_cyc    = 0;
    cur_sel     = s;
    cur_dir     = d;
    req_sel     = s;
    req_dir     = d;
    req_count   = c;
    req_valid   = 1'b1;
    wait_ready();
    check("send_ready", 32'(req_ready), 32'(1));
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_end(output bit got_done, output bit got_err);
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    got_done = done;
    got_err  = error;
  endtask

  task automatic score(input bit got_done, input bit got_err);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0d expected=%0d", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("sb_error", 32'(got_err), 32'(e.is_err));
      check("sb_done", 32'(got_done), 32'(!e.is_err));
      check("sb_steps", 32'(step_pulses), 32'(e.steps));
      check("sb_step_len", 32'(step_cyc), 32'(2 * e.steps));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gd, ge, seen;
    int n;

    repeat (3) @(negedge clock);
    check("rst_outputs", 32'({busy, done, error, pll_phasestep, pll_phaseupdown,
                              pll_phasecounterselect, req_ready}), 32'(0));
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("ready_no_lock", 32'(req_ready), 32'(0));
    pll_locked = 1'b1;
    wait_ready();
    check("ready_lock", 32'(req_ready), 32'(1));

    // Three up-steps on counter 2
    exp_q.push_back('{is_err: 1'b0, steps: 3});
    send(3'd2, 1'b1, 8'd3);
    wait_end(gd, ge);
    score(gd, ge);
    check("t1_busy_at_done", 32'(busy), 32'(0));
    @(negedge clock);
    check("t1_single_done", 32'(done), 32'(0));
    check("t1_ready_after", 32'(req_ready), 32'(1));
    check("t1_idle_outputs", 32'({pll_phasecounterselect, pll_phaseupdown}), 32'(0));

    // Zero-step request
    exp_q.push_back('{is_err: 1'b0, steps: 0});
    send(3'd4, 1'b0, 8'd0);
    check("t2_ready_drop", 32'(req_ready), 32'(0));
    wait_end(gd, ge);
    score(gd, ge);
    @(negedge clock);
    check("t2_done_gone", 32'(done), 32'(0));
    check("t2_ready_back", 32'(req_ready), 32'(1));

    // PLL never lowers phasedone
    pll_stuck = 1'b1;
    exp_q.push_back('{is_err: 1'b1, steps: 1});
    send(3'd1, 1'b1, 8'd1);
    wait_end(gd, ge);
    score(gd, ge);
    check("t3_timeout_cycles", 32'(cyc - last_step_cyc), 32'(TIMEOUT + 1));
    check("t3_busy", 32'(busy), 32'(0));
    @(negedge clock);
    check("t3_ready", 32'(req_ready), 32'(1));
    pll_stuck = 1'b0;

    // Lock loss during the second of four steps
    exp_q.push_back('{is_err: 1'b1, steps: 2});
    send(3'd3, 1'b0, 8'd4);
    n = 0;
    while (step_pulses < 2 && n < 500) begin
      @(negedge clock);
      n++;
    end
    pll_locked = 1'b0;
    wait_end(gd, ge);
    score(gd, ge);
    check("t4_step_low", 32'({pll_phasestep, busy}), 32'(0));
    repeat (5) @(negedge clock);
    check("t4_ready_no_lock", 32'({req_ready, error}), 32'(0));
    pll_locked = 1'b1;
    wait_ready();
    check("t4_ready_relock", 32'(req_ready), 32'(1));

    // Reset while waiting for phasedone to return high
    send(3'd6, 1'b1, 8'd3);
    n = 0;
    while (pd_cnt != 2 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("t5_reached_wait", 32'(pd_cnt), 32'(2));
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_outputs", 32'({busy, done, error, pll_phasestep, pll_phaseupdown,
                                 pll_phasecounterselect, req_ready}), 32'(0));
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (done || error) seen = 1'b1;
    end
    check("t5_no_pulse", 32'(seen), 32'(0));
    exp_q.push_back('{is_err: 1'b0, steps: 2});
    send(3'd5, 1'b0, 8'd2);
    wait_end(gd, ge);
    score(gd, ge);

`ifdef PHASE_POSITION_EN
    check("t6_pos_reset", 32'(phase_position), 32'(0));
    exp_q.push_back('{is_err: 1'b0, steps: 5});
    send(3'd0, 1'b1, 8'd5);
    wait_end(gd, ge);
    score(gd, ge);
    check("t6_pos_up5", 32'(phase_position), 32'(16'sd5));
    @(negedge clock);
    exp_q.push_back('{is_err: 1'b0, steps: 7});
    send(3'd0, 1'b0, 8'd7);
    wait_end(gd, ge);
    score(gd, ge);
    check("t6_pos_minus2", 32'(phase_position), 32'(16'hFFFE));
    @(negedge clock);
    exp_q.push_back('{is_err: 1'b0, steps: 2});
    send(3'd1, 1'b1, 8'd2);
    wait_end(gd, ge);
    score(gd, ge);
    check("t6_pos_other_sel", 32'(phase_position), 32'(16'hFFFE));
`endif

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
